// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the load/store unit.
// One transaction is outstanding at a time; data wins ties unless fetch has been starved.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // Fetch port
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  input  logic        i_kill_i,
  output logic        i_done_o,
  output logic [31:0] i_rdata_o,
  // Data port
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_be_i,
  output logic        d_done_o,
  output logic [31:0] d_rdata_o,
  // Pipeline stalls
  output logic        stall_if_o,
  output logic        stall_mem_o,
  // Memory side
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int unsigned WdW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);
  localparam logic [WdW-1:0]     WdLast    = WdW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGntI,
    StGntD
  } state_e;

  state_e             state_q, state_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic [WdW-1:0]     wd_q, wd_d;
  logic               kill_q, kill_d;
  logic               err_q, err_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;

  logic fetch_ok;
  logic starved;
  logic in_gnt;
  logic timeout;
  logic finish;
  logic fetch_drop;

  assign fetch_ok   = i_req_i & ~i_kill_i;
  assign starved    = (starve_q == StarveMax);
  assign in_gnt     = (state_q != StIdle);
  // Watchdog fires on the last allowed grant cycle only if the memory stayed silent.
  assign timeout    = in_gnt & ~mem_ack_i & (wd_q == WdLast);
  assign finish     = in_gnt & (mem_ack_i | timeout);
  assign fetch_drop = kill_q | i_kill_i;

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    wd_d      = wd_q;
    kill_d    = kill_q;
    err_d     = err_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    i_done_o  = 1'b0;
    i_rdata_o = 32'h0;
    d_done_o  = 1'b0;
    d_rdata_o = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (d_req_i && !(fetch_ok && starved)) begin
          state_d = StGntD;
          req_d   = 1'b1;
          we_d    = d_we_i;
          addr_d  = d_addr_i;
          wdata_d = d_wdata_i;
          be_d    = d_be_i;
          wd_d    = '0;
          if (i_req_i && !starved) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (fetch_ok) begin
          state_d  = StGntI;
          req_d    = 1'b1;
          we_d     = 1'b0;
          addr_d   = i_addr_i;
          wdata_d  = 32'h0;
          be_d     = 4'hF;
          wd_d     = '0;
          kill_d   = 1'b0;
          starve_d = '0;
        end
      end

      StGntI: begin
        if (i_kill_i) begin
          kill_d = 1'b1;
        end
        if (finish) begin
          state_d = StIdle;
          req_d   = 1'b0;
          we_d    = 1'b0;
          kill_d  = 1'b0;
          if (timeout) begin
            err_d = 1'b1;
          end
          // A killed fetch still has to drain, but the pipeline must never see its data.
          if (!fetch_drop) begin
            i_done_o  = 1'b1;
            i_rdata_o = timeout ? NOP_INSTR : mem_rdata_i;
          end
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      StGntD: begin
        if (finish) begin
          state_d   = StIdle;
          req_d     = 1'b0;
          we_d      = 1'b0;
          d_done_o  = 1'b1;
          d_rdata_o = timeout ? 32'h0 : mem_rdata_i;
          if (timeout) begin
            err_d = 1'b1;
          end
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      starve_q <= '0;
      wd_q     <= '0;
      kill_q   <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      be_q     <= 4'h0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wd_q     <= wd_d;
      kill_q   <= kill_d;
      err_q    <= err_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;
  assign err_o       = err_q;

  assign stall_if_o  = i_req_i & ~i_done_o;
  assign stall_mem_o = d_req_i & ~d_done_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requesters and a memory model drive the DUT; expected
// responses are queued at issue time and checked by independent monitors.
module tb_mem_port_arbiter;

  localparam int unsigned STARVE_MAX = 3;
  localparam int unsigned TIMEOUT    = 64;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        i_req_i, i_kill_i, i_done_o;
  logic [31:0] i_addr_i, i_rdata_o;
  logic        d_req_i, d_we_i, d_done_o;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic [3:0]  d_be_i;
  logic        stall_if_o, stall_mem_o;
  logic        mem_req_o, mem_we_o, mem_ack_i, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;

  mem_port_arbiter #(
    .STARVE_MAX(STARVE_MAX),
    .TIMEOUT   (TIMEOUT),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_req_i    (i_req_i),
    .i_addr_i   (i_addr_i),
    .i_kill_i   (i_kill_i),
    .i_done_o   (i_done_o),
    .i_rdata_o  (i_rdata_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_be_i     (d_be_i),
    .d_done_o   (d_done_o),
    .d_rdata_o  (d_rdata_o),
    .stall_if_o (stall_if_o),
    .stall_mem_o(stall_mem_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_be_o   (mem_be_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dtx_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] exp_i[$];   // fetch read data, in completion order
  logic [31:0] exp_d[$];   // data read data
  logic [31:0] exp_mi[$];  // fetch address seen at the memory
  dtx_t        exp_md[$];  // data transaction seen at the memory
  bit          grant_log[$];

  int  force_lat = -1;
  bit  mem_hold  = 1'b0;
  bit  err_exp   = 1'b0;
  int  stall_if_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Memory contents are a fixed function of address so expectations need no ordering.
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (a == 32'h40) return 32'h0050_0093;
    return {a[15:0] ^ 16'h5A3C, a[15:0]};
  endfunction

  // Memory model: ack after a random (or forced) number of grant cycles.
  initial begin : mem_model
    bit busy;
    int cnt, lat;
    busy = 1'b0; cnt = 0; lat = 0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    forever begin
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      if (mem_req_o && !mem_hold) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = 0;
          lat  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        end
        if (cnt == lat) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = rd_fn(mem_addr_o);
          busy        = 1'b0;
        end else begin
          cnt++;
        end
      end else if (!mem_req_o) begin
        busy = 1'b0;
      end
    end
  end

  // Monitor: completions, memory-side grants (with the priority rule) and stalls.
  initial begin : monitor
    bit   req_prev, pend_i_prev, pend_d_prev, ireq_prev, is_i, exp_gnt_i;
    int   starve;
    dtx_t e;
    logic [31:0] a;
    req_prev = 0; pend_i_prev = 0; pend_d_prev = 0; ireq_prev = 0; starve = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        req_prev = 0; pend_i_prev = 0; pend_d_prev = 0; ireq_prev = 0; starve = 0;
      end else begin
        if (i_done_o) begin
          if (exp_i.size() == 0) chk("i_done_unexpected", 32'd1, 32'd0);
          else chk("i_rdata", i_rdata_o, exp_i.pop_front());
        end
        if (d_done_o) begin
          if (exp_d.size() == 0) chk("d_done_unexpected", 32'd1, 32'd0);
          else chk("d_rdata", d_rdata_o, exp_d.pop_front());
        end
        if (mem_req_o && !req_prev) begin
          is_i = (mem_addr_o < 32'h1000);
          if (pend_i_prev && pend_d_prev) exp_gnt_i = (starve == STARVE_MAX);
          else exp_gnt_i = pend_i_prev;
          chk("grant_is_fetch", 32'(is_i), 32'(exp_gnt_i));
          grant_log.push_back(is_i);
          if (is_i) begin
            starve = 0;
            if (exp_mi.size() == 0) chk("fetch_grant_unexpected", 32'd1, 32'd0);
            else begin
              a = exp_mi.pop_front();
              chk("fetch_mem_addr", mem_addr_o, a);
              chk("fetch_mem_we", 32'(mem_we_o), 32'd0);
              chk("fetch_mem_be", 32'(mem_be_o), 32'hF);
            end
          end else begin
            if (ireq_prev && starve < STARVE_MAX) starve++;
            if (exp_md.size() == 0) chk("data_grant_unexpected", 32'd1, 32'd0);
            else begin
              e = exp_md.pop_front();
              chk("data_mem_addr", mem_addr_o, e.addr);
              chk("data_mem_we", 32'(mem_we_o), 32'(e.we));
              chk("data_mem_be", 32'(mem_be_o), 32'(e.be));
              if (e.we) chk("data_mem_wdata", mem_wdata_o, e.wdata);
            end
          end
        end
        chk("stall_if", 32'(stall_if_o), 32'(i_req_i && !i_done_o));
        chk("stall_mem", 32'(stall_mem_o), 32'(d_req_i && !d_done_o));
        chk("err_o", 32'(err_o), 32'(err_exp));
        if (stall_if_o) stall_if_cnt++;
        req_prev    = mem_req_o;
        pend_i_prev = i_req_i && !i_kill_i;
        pend_d_prev = d_req_i;
        ireq_prev   = i_req_i;
      end
    end
  end

  task automatic wait_done(input bit is_i, input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(negedge clk_i);
      seen = is_i ? i_done_o : d_done_o;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s: got no done pulse in 600 cycles, required one", name);
    end
  endtask

  task automatic wait_grant(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(negedge clk_i);
      seen = mem_req_o;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s: got no mem_req_o in 600 cycles, required one", name);
    end
  endtask

  task automatic do_fetch(input logic [31:0] a);
    @(posedge clk_i); #1;
    exp_i.push_back(rd_fn(a));
    exp_mi.push_back(a);
    i_addr_i = a;
    i_req_i  = 1'b1;
    wait_done(1'b1, "fetch_done_timeout");
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be);
    dtx_t e;
    @(posedge clk_i); #1;
    e.addr = a; e.we = we; e.wdata = wd; e.be = be;
    exp_md.push_back(e);
    exp_d.push_back(rd_fn(a));
    d_we_i = we; d_addr_i = a; d_wdata_i = wd; d_be_i = be;
    d_req_i = 1'b1;
    wait_done(1'b0, "data_done_timeout");
  endtask

  task automatic idle_i(input int n);
    repeat (n) begin @(posedge clk_i); #1; i_req_i = 1'b0; end
  endtask

  task automatic idle_d(input int n);
    repeat (n) begin @(posedge clk_i); #1; d_req_i = 1'b0; end
  endtask

  // Fetch that is killed koff grant cycles in; the memory acks lat cycles after grant.
  task automatic kill_fetch(input logic [31:0] a, input int lat, input int koff);
    force_lat = lat;
    @(posedge clk_i); #1;
    exp_mi.push_back(a);
    i_addr_i = a;
    i_req_i  = 1'b1;
    wait_grant("kill_grant_timeout");
    for (int j = 1; j <= lat; j++) begin
      @(posedge clk_i); #1;
      i_kill_i = (j == koff);
    end
    @(posedge clk_i); #1;
    i_kill_i  = 1'b0;
    i_req_i   = 1'b0;
    force_lat = -1;
    repeat (3) @(negedge clk_i);
    chk("killed_fetch_idle", 32'(mem_req_o), 32'd0);
  endtask

  initial begin : global_guard
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "bench did not terminate");
  end

  initial begin : stim
    int got;
    rst_ni = 1'b0;
    i_req_i = 0; i_addr_i = 0; i_kill_i = 0;
    d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_wdata_i = 0; d_be_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_mem_req", 32'(mem_req_o), 32'd0);
    chk("reset_mem_we", 32'(mem_we_o), 32'd0);
    chk("reset_i_done", 32'(i_done_o), 32'd0);
    chk("reset_d_done", 32'(d_done_o), 32'd0);
    chk("reset_err", 32'(err_o), 32'd0);
    @(negedge clk_i); #1;
    rst_ni = 1'b1;

    // Isolated fetch, ack one cycle after mem_req_o.
    force_lat = 1;
    stall_if_cnt = 0;
    do_fetch(32'h40);
    idle_i(1);
    chk("isolated_stall_if_cycles", 32'(stall_if_cnt), 32'd2);
    force_lat = -1;

    // Fetch competing with continuous stores: D,D,D then I.
    grant_log.delete();
    fork
      begin do_fetch(32'h48); idle_i(1); end
      begin repeat (4) do_data(1'b1, 32'h7000, 32'hAB, 4'h1); idle_d(1); end
    join
    chk("starve_grant_count", 32'(grant_log.size()), 32'd5);
    if (grant_log.size() >= 4)
      chk("starve_order", {28'h0, grant_log[0], grant_log[1], grant_log[2], grant_log[3]},
          32'b0001);

    // Fetch with kill held in the same cycle as the request is never granted.
    @(posedge clk_i); #1;
    i_addr_i = 32'h84; i_req_i = 1'b1; i_kill_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("kill_in_idle_no_grant", 32'(mem_req_o), 32'd0);
    end
    @(posedge clk_i); #1;
    i_kill_i = 1'b0; i_req_i = 1'b0;
    do_fetch(32'h84);
    idle_i(1);

    // Kill one cycle before the ack, then kill in the ack cycle itself.
    kill_fetch(32'h100, 2, 1);
    do_fetch(32'h80);
    idle_i(1);
    kill_fetch(32'h104, 1, 1);

    // Watchdog on a load with no ack.
    mem_hold = 1'b1;
    @(posedge clk_i); #1;
    begin
      dtx_t e;
      e.addr = 32'h7100; e.we = 1'b0; e.wdata = 32'h0; e.be = 4'hF;
      exp_md.push_back(e);
    end
    exp_d.push_back(32'h0);
    d_we_i = 1'b0; d_addr_i = 32'h7100; d_be_i = 4'hF; d_req_i = 1'b1;
    got = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_i);
      if (d_done_o) begin got = c; break; end
    end
    chk("watchdog_cycle", 32'(got), 32'd64);
    @(posedge clk_i); #1;
    d_req_i = 1'b0;
    err_exp = 1'b1;
    mem_hold = 1'b0;
    @(negedge clk_i);
    chk("watchdog_err_set", 32'(err_o), 32'd1);
    chk("watchdog_req_dropped", 32'(mem_req_o), 32'd0);
    do_fetch(32'h200);
    idle_i(1);
    repeat (2) @(negedge clk_i);
    chk("err_sticky", 32'(err_o), 32'd1);

    // Asynchronous reset in the middle of a data grant.
    mem_hold = 1'b1;
    @(posedge clk_i); #1;
    begin
      dtx_t e;
      e.addr = 32'h7200; e.we = 1'b0; e.wdata = 32'h0; e.be = 4'h3;
      exp_md.push_back(e);
    end
    d_we_i = 1'b0; d_addr_i = 32'h7200; d_be_i = 4'h3; d_req_i = 1'b1;
    wait_grant("reset_test_grant_timeout");
    repeat (3) @(negedge clk_i);
    #2;
    rst_ni  = 1'b0;
    err_exp = 1'b0;
    #1;
    chk("async_reset_mem_req", 32'(mem_req_o), 32'd0);
    chk("async_reset_d_done", 32'(d_done_o), 32'd0);
    chk("async_reset_err", 32'(err_o), 32'd0);
    d_req_i = 1'b0;
    mem_hold = 1'b0;
    @(negedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      chk("post_reset_idle", 32'(mem_req_o), 32'd0);
    end

    // Randomised mixed traffic.
    fork
      begin
        repeat (40) begin
          do_fetch({20'h0, 10'($urandom_range(0, 1023)), 2'b00});
          idle_i(int'($urandom_range(0, 3)));
        end
        idle_i(1);
      end
      begin
        repeat (40) begin
          do_data(1'($urandom_range(0, 1)), {20'h7, 8'($urandom_range(0, 255)), 2'b00},
                  $urandom, 4'($urandom_range(1, 15)));
          idle_d(int'($urandom_range(0, 2)));
        end
        idle_d(1);
      end
    join

    repeat (5) @(negedge clk_i);
    chk("drain_exp_i", 32'(exp_i.size()), 32'd0);
    chk("drain_exp_d", 32'(exp_d.size()), 32'd0);
    chk("drain_exp_mi", 32'(exp_mi.size()), 32'd0);
    chk("drain_exp_md", 32'(exp_md.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
